// File: rtl/luma_frame_stats.sv
// RGB to 8-bit luma converter with a 3-stage pipeline.
// Also keeps per-frame luma min/max/sum/count and publishes them once per frame.
module luma_frame_stats #(
   parameter int SUM_W = 27,
   parameter int CNT_W = 20
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             DI_VALID,
   input  logic             DI_SOF,
   input  logic [7:0]       DI_0,
   input  logic [7:0]       DI_1,
   input  logic [7:0]       DI_2,
   output logic [7:0]       DO_Y,
   output logic             DO_VALID,
   output logic             DO_SOF,
   output logic [7:0]       STAT_MIN,
   output logic [7:0]       STAT_MAX,
   output logic [SUM_W-1:0] STAT_SUM,
   output logic [CNT_W-1:0] STAT_CNT,
   output logic             STAT_VALID
);

   logic [15:0]      prod_r;
   logic [15:0]      prod_g;
   logic [15:0]      prod_b;
   logic             valid1;
   logic             sof1;
   logic [15:0]      sum2;
   logic             valid2;
   logic             sof2;

   logic [7:0]       acc_min;
   logic [7:0]       acc_max;
   logic [SUM_W-1:0] acc_sum;
   logic [CNT_W-1:0] acc_cnt;
   logic             frame_active;

   logic [SUM_W:0]   sum_inc;
   logic [SUM_W-1:0] sum_sat;
   logic [CNT_W-1:0] cnt_sat;

   // Datapath registers also clear on reset so DO_Y stays deterministic.
   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         prod_r   <= '0;
         prod_g   <= '0;
         prod_b   <= '0;
         valid1   <= 1'b0;
         sof1     <= 1'b0;
         sum2     <= '0;
         valid2   <= 1'b0;
         sof2     <= 1'b0;
         DO_Y     <= '0;
         DO_VALID <= 1'b0;
         DO_SOF   <= 1'b0;
      end else begin
         prod_r   <= 16'(DI_0) * 16'd77;
         prod_g   <= 16'(DI_1) * 16'd150;
         prod_b   <= 16'(DI_2) * 16'd29;
         valid1   <= DI_VALID;
         sof1     <= DI_SOF & DI_VALID;
         sum2     <= prod_r + prod_g + prod_b + 16'd128;
         valid2   <= valid1;
         sof2     <= sof1;
         DO_Y     <= 8'(sum2 >> 8);
         DO_VALID <= valid2;
         DO_SOF   <= sof2;
      end
   end

   always_comb begin
      sum_inc = {1'b0, acc_sum} + (SUM_W+1)'(DO_Y);
      sum_sat = sum_inc[SUM_W] ? '1 : sum_inc[SUM_W-1:0];
      cnt_sat = (&acc_cnt) ? acc_cnt : acc_cnt + CNT_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (!RESET_N) begin
         acc_min      <= '0;
         acc_max      <= '0;
         acc_sum      <= '0;
         acc_cnt      <= '0;
         frame_active <= 1'b0;
         STAT_MIN     <= '0;
         STAT_MAX     <= '0;
         STAT_SUM     <= '0;
         STAT_CNT     <= '0;
         STAT_VALID   <= 1'b0;
      end else begin
         STAT_VALID <= 1'b0;
         if (DO_VALID) begin
            if (DO_SOF) begin
               // The first SOF after reset has no previous frame to publish.
               if (frame_active) begin
                  STAT_MIN   <= acc_min;
                  STAT_MAX   <= acc_max;
                  STAT_SUM   <= acc_sum;
                  STAT_CNT   <= acc_cnt;
                  STAT_VALID <= 1'b1;
               end
               acc_min      <= DO_Y;
               acc_max      <= DO_Y;
               acc_sum      <= SUM_W'(DO_Y);
               acc_cnt      <= CNT_W'(1);
               frame_active <= 1'b1;
            end else if (frame_active) begin
               if (DO_Y < acc_min)
                  acc_min <= DO_Y;
               if (DO_Y > acc_max)
                  acc_max <= DO_Y;
               acc_sum <= sum_sat;
               acc_cnt <= cnt_sat;
            end
         end
      end
   end

endmodule

// File: tb/tb_luma_frame_stats.sv
// Directed bench for luma_frame_stats: luma math, latency, frame stats,
// gaps, mid-frame reset, and saturation on a narrow-width instance.
module tb_luma_frame_stats;

   logic        clk;
   logic        rst_n;
   logic        di_valid;
   logic        di_sof;
   logic [7:0]  di_0;
   logic [7:0]  di_1;
   logic [7:0]  di_2;

   logic [7:0]  do_y;
   logic        do_valid;
   logic        do_sof;
   logic [7:0]  st_min;
   logic [7:0]  st_max;
   logic [26:0] st_sum;
   logic [19:0] st_cnt;
   logic        st_valid;

   logic [7:0]  n_y;
   logic        n_valid;
   logic        n_sof;
   logic [7:0]  n_min;
   logic [7:0]  n_max;
   logic [9:0]  n_sum;
   logic [2:0]  n_cnt;
   logic        n_stv;

   int total;
   int bad;
   int pubs;
   int sofs;

   luma_frame_stats dut (
      .CLK(clk), .RESET_N(rst_n),
      .DI_VALID(di_valid), .DI_SOF(di_sof),
      .DI_0(di_0), .DI_1(di_1), .DI_2(di_2),
      .DO_Y(do_y), .DO_VALID(do_valid), .DO_SOF(do_sof),
      .STAT_MIN(st_min), .STAT_MAX(st_max),
      .STAT_SUM(st_sum), .STAT_CNT(st_cnt),
      .STAT_VALID(st_valid)
   );

   luma_frame_stats #(.SUM_W(10), .CNT_W(3)) dut_n (
      .CLK(clk), .RESET_N(rst_n),
      .DI_VALID(di_valid), .DI_SOF(di_sof),
      .DI_0(di_0), .DI_1(di_1), .DI_2(di_2),
      .DO_Y(n_y), .DO_VALID(n_valid), .DO_SOF(n_sof),
      .STAT_MIN(n_min), .STAT_MAX(n_max),
      .STAT_SUM(n_sum), .STAT_CNT(n_cnt),
      .STAT_VALID(n_stv)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (st_valid === 1'b1)
         pubs <= pubs + 1;
      if (do_sof === 1'b1)
         sofs <= sofs + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic px(input logic v, input logic s, input logic [7:0] r,
                     input logic [7:0] g, input logic [7:0] b);
      di_valid = v;
      di_sof   = s;
      di_0     = r;
      di_1     = g;
      di_2     = b;
      @(posedge clk);
      #1;
   endtask

   task automatic gy(input logic v, input logic s, input logic [7:0] y);
      px(v, s, y, y, y);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         px(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
   endtask

   task automatic chk_pub(input string tag, input logic [7:0] mn,
                          input logic [7:0] mx, input logic [31:0] sm,
                          input logic [31:0] ct);
      chk({tag, "_stv"}, 32'(st_valid), 32'd1);
      chk({tag, "_min"}, 32'(st_min), 32'(mn));
      chk({tag, "_max"}, 32'(st_max), 32'(mx));
      chk({tag, "_sum"}, 32'(st_sum), sm);
      chk({tag, "_cnt"}, 32'(st_cnt), ct);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      pubs  = 0;
      sofs  = 0;
      rst_n    = 1'b0;
      di_valid = 1'b0;
      di_sof   = 1'b0;
      di_0     = 8'd0;
      di_1     = 8'd0;
      di_2     = 8'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_y", 32'(do_y), 32'd0);
      chk("rst_dv", 32'(do_valid), 32'd0);
      chk("rst_ds", 32'(do_sof), 32'd0);
      chk("rst_min", 32'(st_min), 32'd0);
      chk("rst_max", 32'(st_max), 32'd0);
      chk("rst_sum", 32'(st_sum), 32'd0);
      chk("rst_cnt", 32'(st_cnt), 32'd0);
      chk("rst_stv", 32'(st_valid), 32'd0);
      rst_n = 1'b1;

      // latency: valid appears after the third clock
      gy(1'b1, 1'b0, 8'd200);
      chk("lat_dv1", 32'(do_valid), 32'd0);
      gy(1'b1, 1'b0, 8'd200);
      chk("lat_dv2", 32'(do_valid), 32'd0);
      gy(1'b1, 1'b0, 8'd200);
      chk("lat_dv3", 32'(do_valid), 32'd1);
      chk("lat_y", 32'(do_y), 32'd200);
      chk("lat_stv", 32'(st_valid), 32'd0);
      chk("lat_sum", 32'(st_sum), 32'd0);

      // extremes: (77*255+128)>>8=77, (150*255+128)>>8=149, (29*255+128)>>8=29
      px(1'b1, 1'b0, 8'd255, 8'd0, 8'd0);
      px(1'b1, 1'b0, 8'd0, 8'd255, 8'd0);
      px(1'b1, 1'b0, 8'd0, 8'd0, 8'd255);
      chk("ext_r", 32'(do_y), 32'd77);
      px(1'b1, 1'b0, 8'd255, 8'd255, 8'd255);
      chk("ext_g", 32'(do_y), 32'd149);
      px(1'b1, 1'b0, 8'd0, 8'd0, 8'd0);
      chk("ext_b", 32'(do_y), 32'd29);
      idle(1);
      chk("ext_w", 32'(do_y), 32'd255);
      idle(1);
      chk("ext_k", 32'(do_y), 32'd0);
      chk("ext_kv", 32'(do_valid), 32'd1);
      idle(1);
      chk("ext_dv0", 32'(do_valid), 32'd0);
      chk("ext_stv", 32'(st_valid), 32'd0);

      // frame 10,50,5,30 then next SOF
      gy(1'b1, 1'b1, 8'd10);
      gy(1'b1, 1'b0, 8'd50);
      gy(1'b1, 1'b0, 8'd5);
      chk("fr_sof", 32'(do_sof), 32'd1);
      chk("fr_y0", 32'(do_y), 32'd10);
      gy(1'b1, 1'b0, 8'd30);
      chk("fr_sof0", 32'(do_sof), 32'd0);
      chk("fr_nopub", 32'(st_valid), 32'd0);
      gy(1'b1, 1'b1, 8'd77);
      idle(3);
      chk_pub("fr", 8'd5, 8'd50, 32'd95, 32'd4);
      idle(1);
      chk("fr_stv0", 32'(st_valid), 32'd0);
      chk("fr_hold_min", 32'(st_min), 32'd5);
      chk("fr_hold_sum", 32'(st_sum), 32'd95);
      chk("fr_pubs", 32'(pubs), 32'd1);

      // gaps plus an invalid SOF pulse; the SOF of 10 publishes frame [77]
      gy(1'b1, 1'b1, 8'd10);
      idle(1);
      gy(1'b1, 1'b0, 8'd50);
      gy(1'b0, 1'b1, 8'd99);
      chk_pub("one", 8'd77, 8'd77, 32'd77, 32'd1);
      gy(1'b1, 1'b0, 8'd5);
      chk("gap_stv0", 32'(st_valid), 32'd0);
      idle(1);
      gy(1'b1, 1'b0, 8'd30);
      idle(1);
      chk("gap_nopub", 32'(st_valid), 32'd0);
      gy(1'b1, 1'b1, 8'd60);
      idle(3);
      chk_pub("gap", 8'd5, 8'd50, 32'd95, 32'd4);
      idle(2);
      chk("gap_pubs", 32'(pubs), 32'd3);
      chk("gap_sofs", 32'(sofs), 32'd4);

      // reset mid-frame discards the partial frame
      gy(1'b1, 1'b0, 8'd1);
      gy(1'b1, 1'b0, 8'd2);
      gy(1'b1, 1'b0, 8'd3);
      idle(3);
      rst_n = 1'b0;
      idle(1);
      chk("mrst_min", 32'(st_min), 32'd0);
      chk("mrst_cnt", 32'(st_cnt), 32'd0);
      rst_n = 1'b1;
      gy(1'b1, 1'b1, 8'd100);
      gy(1'b1, 1'b0, 8'd120);
      gy(1'b1, 1'b1, 8'd7);
      idle(2);
      chk("mrst_nopub", 32'(st_valid), 32'd0);
      idle(1);
      chk_pub("mrst", 8'd100, 8'd120, 32'd220, 32'd2);
      idle(1);
      chk("mrst_pubs", 32'(pubs), 32'd4);

      // saturation: narrow instance holds at 7 / 1023
      gy(1'b1, 1'b1, 8'd255);
      for (int i = 0; i < 9; i++)
         gy(1'b1, 1'b0, 8'd255);
      gy(1'b1, 1'b1, 8'd0);
      idle(3);
      chk_pub("wide", 8'd255, 8'd255, 32'd2550, 32'd10);
      chk("sat_stv", 32'(n_stv), 32'd1);
      chk("sat_cnt", 32'(n_cnt), 32'd7);
      chk("sat_sum", 32'(n_sum), 32'd1023);
      chk("sat_min", 32'(n_min), 32'd255);
      idle(2);
      chk("end_sofs", 32'(sofs), 32'd8);
      chk("end_pubs", 32'(pubs), 32'd6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
